// File: rtl/fir_out_decim.sv
// fir_out_decim: warm-up discard, decimation by DECIM and FWFT output FIFO.
// Optional macro FIR_DECIM_AVG_EN selects boxcar-average instead of pick.
module fir_out_decim #(
    parameter int DATA_W     = 8,
    parameter int DECIM      = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int WARMUP     = 7
) (
    input  logic                            clk,
    input  logic                            Rst_n,
    input  logic [DATA_W-1:0]               Yin,
    input  logic                            in_en,
    output logic [DATA_W-1:0]               out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic                            overflow
);

    localparam int LOG2 = (DECIM > 1) ? $clog2(DECIM) : 0;
    localparam int PH_W = (DECIM > 1) ? LOG2 : 1;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = AW + 1;
    localparam int WW   = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;

    localparam logic [PH_W-1:0] PH_LAST  = PH_W'(DECIM - 1);
    localparam logic [CW-1:0]   FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [WW-1:0]   WARM_MAX = WW'(WARMUP);

    logic [WW-1:0]     warm_cnt;
    logic [PH_W-1:0]   phase;
    logic              warm_done;
    logic              qual;
    logic              push_req;
    logic [DATA_W-1:0] push_data;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [DATA_W-1:0] last_q;
    logic              full;
    logic              pop;
    logic              push;

    assign warm_done = (warm_cnt == WARM_MAX);
    assign qual      = in_en && warm_done;

    // Count qualified samples until the FIR pipeline has filled.
    always_ff @(posedge clk) begin
        if (!Rst_n) begin
            warm_cnt <= '0;
        end else if (in_en && !warm_done) begin
            warm_cnt <= warm_cnt + 1'b1;
        end
    end

    // Decimation phase, advanced only by post-warm-up qualified samples.
    always_ff @(posedge clk) begin
        if (!Rst_n) begin
            phase <= '0;
        end else if (qual) begin
            phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
        end
    end

`ifdef FIR_DECIM_AVG_EN
    localparam int ACC_W = DATA_W + LOG2;

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_sum;

    // Running sum including the current sample; phase 0 restarts it.
    always_comb begin
        acc_sum = ACC_W'(Yin);
        if (phase != '0) begin
            acc_sum = acc + ACC_W'(Yin);
        end
    end

    // Accumulator register for the boxcar window.
    always_ff @(posedge clk) begin
        if (!Rst_n) begin
            acc <= '0;
        end else if (qual) begin
            acc <= acc_sum;
        end
    end

    assign push_req  = qual && (phase == PH_LAST);
    assign push_data = DATA_W'(acc_sum >> LOG2);
`else
    assign push_req  = qual && (phase == '0);
    assign push_data = Yin;
`endif

    assign full      = (count == FULL_CNT);
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign push      = push_req && (!full || pop);

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers, occupancy, sticky overflow and held output value.
    always_ff @(posedge clk) begin
        if (!Rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            last_q   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                last_q <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push_req && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    assign out_data   = out_valid ? mem[rd_ptr] : last_q;
    assign fifo_count = count;

endmodule

// File: tb/tb_fir_out_decim.sv
// tb_fir_out_decim: directed checks on a DECIM=4 and a DECIM=1 instance.
// Average-mode expectations are used when FIR_DECIM_AVG_EN is defined.
module tb_fir_out_decim;

    logic       clk = 1'b0;

    logic       a_rst = 1'b0;
    logic [7:0] a_yin = '0;
    logic       a_en  = 1'b0;
    logic       a_rdy = 1'b0;
    logic [7:0] a_data;
    logic       a_valid;
    logic [3:0] a_count;
    logic       a_ovf;

    logic       b_rst = 1'b0;
    logic [7:0] b_yin = '0;
    logic       b_en  = 1'b0;
    logic       b_rdy = 1'b0;
    logic [7:0] b_data;
    logic       b_valid;
    logic [3:0] b_count;
    logic       b_ovf;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    fir_out_decim #(.DATA_W(8), .DECIM(4), .FIFO_DEPTH(8), .WARMUP(7)) u_a (
        .clk(clk), .Rst_n(a_rst), .Yin(a_yin), .in_en(a_en),
        .out_data(a_data), .out_valid(a_valid), .out_ready(a_rdy),
        .fifo_count(a_count), .overflow(a_ovf)
    );

    fir_out_decim #(.DATA_W(8), .DECIM(1), .FIFO_DEPTH(8), .WARMUP(7)) u_b (
        .clk(clk), .Rst_n(b_rst), .Yin(b_yin), .in_en(b_en),
        .out_data(b_data), .out_valid(b_valid), .out_ready(b_rdy),
        .fifo_count(b_count), .overflow(b_ovf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    initial begin
        tick();
        tick();
        a_rst = 1'b1;
        b_rst = 1'b1;
        chk("rst_a_valid", a_valid, 0);
        chk("rst_a_data", a_data, 0);
        chk("rst_a_count", a_count, 0);
        chk("rst_a_ovf", a_ovf, 0);
        chk("rst_b_valid", b_valid, 0);

`ifndef FIR_DECIM_AVG_EN
        // continuous input, DECIM=4
        a_en = 1'b1;
        for (int k = 0; k < 7; k++) begin
            a_yin = 8'(10 + k);
            tick();
        end
        chk("s1_warm_valid", a_valid, 0);
        a_yin = 8'd17;
        tick();
        chk("s1_first_valid", a_valid, 1);
        chk("s1_first_data", a_data, 17);
        chk("s1_first_count", a_count, 1);
        for (int k = 18; k <= 20; k++) begin
            a_yin = 8'(k);
            tick();
        end
        chk("s1_hold_count", a_count, 1);
        a_yin = 8'd21;
        tick();
        chk("s1_second_count", a_count, 2);
        chk("s1_head_kept", a_data, 17);
        for (int k = 22; k <= 25; k++) begin
            a_yin = 8'(k);
            tick();
        end
        chk("s1_third_count", a_count, 3);
        a_en  = 1'b0;
        a_rdy = 1'b1;
        tick();
        chk("s1_pop1_data", a_data, 21);
        chk("s1_pop1_count", a_count, 2);
        tick();
        chk("s1_pop2_data", a_data, 25);
        tick();
        chk("s1_empty_valid", a_valid, 0);
        chk("s1_empty_hold", a_data, 25);
        tick();
        chk("s1_rdy_empty_cnt", a_count, 0);
        a_rdy = 1'b0;

        // in_en toggling every cycle
        a_rst = 1'b0;
        tick();
        a_rst = 1'b1;
        chk("s2_rst_count", a_count, 0);
        chk("s2_rst_data", a_data, 0);
        for (int c = 0; c < 14; c++) begin
            a_en  = (c % 2 == 0);
            a_yin = (c % 2 == 0) ? 8'(10 + c / 2) : 8'hAA;
            tick();
        end
        chk("s2_warm_valid", a_valid, 0);
        a_en  = 1'b1;
        a_yin = 8'd17;
        tick();
        chk("s2_first_valid", a_valid, 1);
        chk("s2_first_data", a_data, 17);
        for (int k = 18; k <= 20; k++) begin
            a_en  = 1'b0;
            a_yin = 8'd0;
            tick();
            a_en  = 1'b1;
            a_yin = 8'(k);
            tick();
        end
        a_en  = 1'b0;
        a_yin = 8'd0;
        tick();
        chk("s2_idle_count", a_count, 1);
        a_en  = 1'b1;
        a_yin = 8'd21;
        tick();
        chk("s2_second_count", a_count, 2);
        a_en  = 1'b0;
        a_rdy = 1'b1;
        tick();
        chk("s2_pop_data", a_data, 21);
        a_rdy = 1'b0;
`else
        // boxcar average, DECIM=4
        a_en  = 1'b1;
        a_yin = 8'd0;
        for (int k = 0; k < 7; k++) tick();
        a_yin = 8'd8;
        tick();
        a_yin = 8'd9;
        tick();
        a_yin = 8'd10;
        tick();
        chk("s6_mid_valid", a_valid, 0);
        a_yin = 8'd12;
        tick();
        chk("s6_avg_valid", a_valid, 1);
        chk("s6_avg_data", a_data, 9);
        a_yin = 8'd255;
        for (int k = 0; k < 4; k++) tick();
        chk("s6_max_count", a_count, 2);
        a_en  = 1'b0;
        a_rdy = 1'b1;
        tick();
        chk("s6_max_data", a_data, 255);
        chk("s6_max_left", a_count, 1);
        a_rdy = 1'b0;
`endif

        // DECIM=1 fill to full, push+pop when full, then overflow
        b_en = 1'b1;
        for (int k = 0; k < 15; k++) begin
            b_yin = 8'(10 + k);
            tick();
        end
        chk("s3_full_count", b_count, 8);
        chk("s3_full_ovf", b_ovf, 0);
        chk("s3_full_head", b_data, 17);
        b_yin = 8'd25;
        b_rdy = 1'b1;
        tick();
        chk("s4_pp_count", b_count, 8);
        chk("s4_pp_ovf", b_ovf, 0);
        chk("s4_pp_head", b_data, 18);
        b_yin = 8'd26;
        b_rdy = 1'b0;
        tick();
        chk("s3_ovf_set", b_ovf, 1);
        chk("s3_ovf_count", b_count, 8);
        chk("s3_ovf_head", b_data, 18);
        b_en  = 1'b0;
        b_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i < 7) chk("s3_drain_data", b_data, 19 + i);
            else chk("s3_drain_valid", b_valid, 0);
        end
        chk("s3_drain_hold", b_data, 25);
        chk("s3_ovf_sticky", b_ovf, 1);
        b_rdy = 1'b0;

        // reset with five entries buffered
        b_en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            b_yin = 8'(100 + k);
            tick();
        end
        chk("s5_pre_count", b_count, 5);
        chk("s5_pre_head", b_data, 100);
        b_rst = 1'b0;
        tick();
        b_rst = 1'b1;
        chk("s5_rst_valid", b_valid, 0);
        chk("s5_rst_count", b_count, 0);
        chk("s5_rst_ovf", b_ovf, 0);
        chk("s5_rst_data", b_data, 0);
        for (int k = 0; k < 7; k++) begin
            b_yin = 8'(50 + k);
            tick();
        end
        chk("s5_rewarm_valid", b_valid, 0);
        b_yin = 8'd57;
        tick();
        chk("s5_after_valid", b_valid, 1);
        chk("s5_after_data", b_data, 57);
        b_en = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
